// File: rtl/sram_like_responder_pkg.sv
// sram_like_pkg: shared types and constants for the sram-like responder.
//   - size_e        : request size encodings (byte / half / word)
//   - MAX_LATENCY   : largest supported response latency
//   - AGE_W         : width of the per-entry latency countdown
//   - resp_entry_t  : one queued response {is_wr, data, age}
package sram_like_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  localparam int DATA_W      = 32;
  localparam int MAX_LATENCY = 7;
  localparam int AGE_W       = $clog2(MAX_LATENCY + 1);

  typedef struct packed {
    logic              is_wr;
    logic [DATA_W-1:0] data;
    logic [AGE_W-1:0]  age;
  } resp_entry_t;

endpackage

// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if: the sram-like request/response bus.
//   master modport: the initiator (drives req/wr/size/addr/wstrb/wdata and
//                   the two stall test hooks, receives addr_ok/data_ok/rdata)
//   slave modport : the responder (the opposite directions)
// Handshake: a request is taken in any cycle where req & addr_ok; addr_ok
// never depends on req. A response is delivered in any cycle where data_ok
// is high; the initiator has no way to refuse it.
interface sram_like_responder_if;
  import sram_like_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              addr_stall;
  logic              data_stall;

  modport master (
    output req, wr, size, addr, wstrb, wdata, addr_stall, data_stall,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata, addr_stall, data_stall,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_responder_resp_fifo.sv
// resp_fifo: in-order response queue with a per-entry latency countdown.
//   clk_i, rst_i   : clock, synchronous active-high reset (invalidates all)
//   push_i         : enqueue push_entry_i at the tail
//   push_entry_i   : entry to enqueue
//   pop_i          : dequeue the head (ignored when the head is invalid)
//   head_valid_o   : head entry is valid
//   head_entry_o   : head entry contents
//   count_o        : number of valid entries
// The caller guarantees push_i only when there is room or a pop happens in
// the same cycle.
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  resp_entry_t                  push_entry_i,
  input  logic                         pop_i,
  output logic                         head_valid_o,
  output resp_entry_t                  head_entry_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  resp_entry_t      entry_q [DEPTH];
  resp_entry_t      entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok = pop_i & valid_q[rd_ptr_q];

  always_comb begin
    entry_d  = entry_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && entry_q[i].age != '0) begin
        entry_d[i].age = entry_q[i].age - AGE_W'(1);
      end
    end
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = next_ptr(rd_ptr_q);
    end
    // Push after pop: on a full queue both pointers name the same slot and
    // the new entry must win over the invalidation.
    if (push_i) begin
      entry_d[wr_ptr_q] = push_entry_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  assign head_valid_o = valid_q[rd_ptr_q];
  assign head_entry_o = entry_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: target end of the sram-like bus backed by a
// word-addressed 32-bit memory of 2^ADDR_WIDTH words.
//   clk   : clock
//   reset : synchronous active-high reset (clears the response queue only)
//   bus   : sram-like bus, slave side
// Requests are accepted on req & addr_ok and answered on data_ok exactly
// LATENCY cycles later (absent stalls), strictly in order, with up to
// MAX_OUTSTANDING unanswered requests in flight.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_like_responder_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_W-1:0]     mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  head_valid;
  resp_entry_t           head_entry;
  resp_entry_t           push_entry;
  logic [CNT_W-1:0]      count;
  logic                  data_ok_w;
  logic                  addr_ok_w;
  logic                  hs;
  logic                  unused_bits;

  // Upper address bits fall away, so addresses wrap modulo memory size.
  assign word_idx = bus.addr[ADDR_WIDTH+1:2];

  // Byte offset and size do not influence the access: reads return the
  // whole aligned word and writes are steered by wstrb alone.
  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:ADDR_WIDTH+2]};

  // Gated by reset so stale queue contents never leak out while the queue
  // is being cleared.
  assign data_ok_w = ~reset & head_valid & (head_entry.age == '0) & ~bus.data_stall;

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign addr_ok_w = ~reset & ~bus.addr_stall &
                     ((count < CNT_W'(MAX_OUTSTANDING)) | data_ok_w);

  assign hs = bus.req & addr_ok_w;

  // Read data is captured at the handshake; earlier writes have already
  // landed in the array at previous clock edges.
  always_comb begin
    push_entry       = '0;
    push_entry.is_wr = bus.wr;
    push_entry.data  = bus.wr ? '0 : mem_q[word_idx];
    push_entry.age   = AGE_W'(LATENCY - 1);
  end

  always_ff @(posedge clk) begin
    if (hs && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk_i        (clk),
    .rst_i        (reset),
    .push_i       (hs),
    .push_entry_i (push_entry),
    .pop_i        (data_ok_w),
    .head_valid_o (head_valid),
    .head_entry_o (head_entry),
    .count_o      (count)
  );

  assign bus.addr_ok = addr_ok_w;
  assign bus.data_ok = data_ok_w;
  assign bus.rdata   = (data_ok_w && !head_entry.is_wr) ? head_entry.data : '0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: one instance with LATENCY=1 and
// one with LATENCY=3, both MAX_OUTSTANDING=2, sharing clock and reset.
module tb_sram_like_responder;
  import sram_like_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sram_like_responder_if bus1();
  sram_like_responder_if bus3();

  sram_like_responder #(.ADDR_WIDTH(12), .LATENCY(1), .MAX_OUTSTANDING(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  sram_like_responder #(.ADDR_WIDTH(12), .LATENCY(3), .MAX_OUTSTANDING(2)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus1.req = 1'b0; bus1.wr = 1'b0; bus1.size = SIZE_W; bus1.addr = '0;
    bus1.wstrb = '0; bus1.wdata = '0; bus1.addr_stall = 1'b0; bus1.data_stall = 1'b0;
    bus3.req = 1'b0; bus3.wr = 1'b0; bus3.size = SIZE_W; bus3.addr = '0;
    bus3.wstrb = '0; bus3.wdata = '0; bus3.addr_stall = 1'b0; bus3.data_stall = 1'b0;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [3:0] wstrb, input logic [31:0] wdata);
    bus1.req = req; bus1.wr = wr; bus1.addr = addr; bus1.wstrb = wstrb; bus1.wdata = wdata;
  endtask

  // Issue one request on bus1 and hold it until accepted (bounded), then drain.
  task automatic send1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic ok = 1'b0;
    drive1(1'b1, wr, addr, 4'hF, wdata);
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (bus1.addr_ok) ok = 1'b1;
      next_cycle();
    end
    bus1.req = 1'b0;
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL send1_accept: addr_ok never seen for addr %h", addr); end
    for (int i = 0; i < 3; i++) next_cycle();
  endtask

  task automatic send3(input logic [31:0] addr, input logic [31:0] wdata);
    logic ok = 1'b0;
    bus3.req = 1'b1; bus3.wr = 1'b1; bus3.addr = addr; bus3.wstrb = 4'hF; bus3.wdata = wdata;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (bus3.addr_ok) ok = 1'b1;
      next_cycle();
    end
    bus3.req = 1'b0;
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL send3_accept: addr_ok never seen for addr %h", addr); end
    for (int i = 0; i < 6; i++) next_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus1.req = 1'b1; bus3.req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vec_cnt++; if (bus1.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL rst_addr_ok1: got %b want 0", bus1.addr_ok); end
      vec_cnt++; if (bus1.data_ok !== 1'b0) begin err_cnt++; $display("FAIL rst_data_ok1: got %b want 0", bus1.data_ok); end
      vec_cnt++; if (bus3.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL rst_addr_ok3: got %b want 0", bus3.addr_ok); end
      vec_cnt++; if (bus3.data_ok !== 1'b0) begin err_cnt++; $display("FAIL rst_data_ok3: got %b want 0", bus3.data_ok); end
      next_cycle();
    end
    reset = 1'b0;
    bus1.req = 1'b0; bus3.req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus1.data_ok !== 1'b0) begin err_cnt++; $display("FAIL post_rst_data_ok1: got %b want 0", bus1.data_ok); end
    vec_cnt++; if (bus3.data_ok !== 1'b0) begin err_cnt++; $display("FAIL post_rst_data_ok3: got %b want 0", bus3.data_ok); end
    next_cycle();
  endtask

  task automatic test_write_read();
    logic        req_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        wr_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        dok_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd_t  [4] = '{32'h0, 32'h0, 32'h12345678, 32'h0};
    for (int c = 0; c < 4; c++) begin
      drive1(req_t[c], wr_t[c], 32'h1C000000, 4'hF, 32'h12345678);
      @(negedge clk);
      if (req_t[c]) begin
        vec_cnt++; if (bus1.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL wr_rd_addr_ok c%0d: got %b want 1", c, bus1.addr_ok); end
      end
      vec_cnt++; if (bus1.data_ok !== dok_t[c]) begin err_cnt++; $display("FAIL wr_rd_data_ok c%0d: got %b want %b", c, bus1.data_ok, dok_t[c]); end
      vec_cnt++; if (bus1.rdata !== rd_t[c]) begin err_cnt++; $display("FAIL wr_rd_rdata c%0d: got %h want %h", c, bus1.rdata, rd_t[c]); end
      next_cycle();
    end
  endtask

  task automatic test_partial_write();
    logic        req_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        wr_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  st_t  [6] = '{4'b0010, 4'h0, 4'b0000, 4'h0, 4'h0, 4'h0};
    logic [31:0] wd_t  [6] = '{32'h0000AB00, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    logic        dok_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd_t  [6] = '{32'h0, 32'h0, 32'h1234AB78, 32'h0, 32'h1234AB78, 32'h0};
    for (int c = 0; c < 6; c++) begin
      drive1(req_t[c], wr_t[c], 32'h1C000000, st_t[c], wd_t[c]);
      @(negedge clk);
      vec_cnt++; if (bus1.data_ok !== dok_t[c]) begin err_cnt++; $display("FAIL partial_data_ok c%0d: got %b want %b", c, bus1.data_ok, dok_t[c]); end
      vec_cnt++; if (bus1.rdata !== rd_t[c]) begin err_cnt++; $display("FAIL partial_rdata c%0d: got %h want %h", c, bus1.rdata, rd_t[c]); end
      next_cycle();
    end
  endtask

  task automatic test_latency3();
    logic [31:0] addr_t [4] = '{32'h0, 32'h4, 32'h8, 32'h8};
    logic        aok_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        dok_t  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] rd_t   [8] = '{32'h0, 32'h0, 32'h0, 32'hA0000000, 32'hA1111111, 32'h0, 32'hA2222222, 32'h0};
    send3(32'h0, 32'hA0000000);
    send3(32'h4, 32'hA1111111);
    send3(32'h8, 32'hA2222222);
    bus3.wr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus3.req = (c < 4);
      if (c < 4) bus3.addr = addr_t[c];
      @(negedge clk);
      if (c < 4) begin
        vec_cnt++; if (bus3.addr_ok !== aok_t[c]) begin err_cnt++; $display("FAIL lat3_addr_ok c%0d: got %b want %b", c, bus3.addr_ok, aok_t[c]); end
      end
      vec_cnt++; if (bus3.data_ok !== dok_t[c]) begin err_cnt++; $display("FAIL lat3_data_ok c%0d: got %b want %b", c, bus3.data_ok, dok_t[c]); end
      vec_cnt++; if (bus3.rdata !== rd_t[c]) begin err_cnt++; $display("FAIL lat3_rdata c%0d: got %h want %h", c, bus3.rdata, rd_t[c]); end
      next_cycle();
    end
    bus3.req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        dok_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd_t  [6] = '{32'h0, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'h0};
    for (int i = 0; i < 8; i++) send1(1'b1, 32'((16 + i) * 4), 32'hC0DE0000 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      drive1(c < 4, 1'b0, 32'((16 + c) * 4), 4'h0, 32'h0);
      @(negedge clk);
      if (c < 4) begin
        vec_cnt++; if (bus1.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL b2b_addr_ok c%0d: got %b want 1", c, bus1.addr_ok); end
      end
      vec_cnt++; if (bus1.data_ok !== dok_t[c]) begin err_cnt++; $display("FAIL b2b_data_ok c%0d: got %b want %b", c, bus1.data_ok, dok_t[c]); end
      vec_cnt++; if (bus1.rdata !== rd_t[c]) begin err_cnt++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, bus1.rdata, rd_t[c]); end
      next_cycle();
    end
  endtask

  task automatic test_data_stall();
    logic        aok_t [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        dok_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd_t  [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'hC0DE0000, 32'hC0DE0001, 32'h0};
    for (int c = 0; c < 10; c++) begin
      bus1.data_stall = (c < 7);
      drive1(c < 2, 1'b0, 32'((16 + c) * 4), 4'h0, 32'h0);
      @(negedge clk);
      vec_cnt++; if (bus1.addr_ok !== aok_t[c]) begin err_cnt++; $display("FAIL dstall_addr_ok c%0d: got %b want %b", c, bus1.addr_ok, aok_t[c]); end
      vec_cnt++; if (bus1.data_ok !== dok_t[c]) begin err_cnt++; $display("FAIL dstall_data_ok c%0d: got %b want %b", c, bus1.data_ok, dok_t[c]); end
      vec_cnt++; if (bus1.rdata !== rd_t[c]) begin err_cnt++; $display("FAIL dstall_rdata c%0d: got %h want %h", c, bus1.rdata, rd_t[c]); end
      next_cycle();
    end
    bus1.data_stall = 1'b0;
  endtask

  task automatic test_addr_stall();
    int          sent = 0;
    int          recv = 0;
    logic [31:0] exp_v;
    exp_q.delete();
    for (int c = 0; c < 60 && !(sent == 8 && recv == 8); c++) begin
      bus1.addr_stall = (c % 2 == 0);
      drive1(sent < 8, 1'b0, 32'((16 + sent) * 4), 4'h0, 32'h0);
      @(negedge clk);
      if (bus1.addr_stall) begin
        vec_cnt++; if (bus1.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL astall_addr_ok c%0d: got %b want 0", c, bus1.addr_ok); end
      end
      if (bus1.data_ok) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL astall_spurious c%0d: data_ok with rdata %h, nothing outstanding", c, bus1.rdata);
        end else begin
          exp_v = exp_q.pop_front();
          recv++;
          if (bus1.rdata !== exp_v) begin err_cnt++; $display("FAIL astall_rdata #%0d: got %h want %h", recv, bus1.rdata, exp_v); end
        end
      end
      if (bus1.req && bus1.addr_ok) begin
        exp_q.push_back(32'hC0DE0000 + 32'(sent));
        sent++;
      end
      next_cycle();
    end
    bus1.req = 1'b0; bus1.addr_stall = 1'b0;
    vec_cnt++; if (sent != 8) begin err_cnt++; $display("FAIL astall_hs_count: got %0d want 8", sent); end
    vec_cnt++; if (recv != 8) begin err_cnt++; $display("FAIL astall_resp_count: got %0d want 8", recv); end
  endtask

  task automatic test_reset_midop();
    logic        rst_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        stl_t [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        req_t [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] adr_t [8] = '{32'h40, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h0};
    logic        chk_t [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        aok_t [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        dok_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] rd_t  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC0DE0000};
    for (int c = 0; c < 8; c++) begin
      reset = rst_t[c];
      bus1.data_stall = stl_t[c];
      drive1(req_t[c], 1'b0, adr_t[c], 4'h0, 32'h0);
      @(negedge clk);
      if (chk_t[c]) begin
        vec_cnt++; if (bus1.addr_ok !== aok_t[c]) begin err_cnt++; $display("FAIL midrst_addr_ok c%0d: got %b want %b", c, bus1.addr_ok, aok_t[c]); end
      end
      vec_cnt++; if (bus1.data_ok !== dok_t[c]) begin err_cnt++; $display("FAIL midrst_data_ok c%0d: got %b want %b", c, bus1.data_ok, dok_t[c]); end
      vec_cnt++; if (bus1.rdata !== rd_t[c]) begin err_cnt++; $display("FAIL midrst_rdata c%0d: got %h want %h", c, bus1.rdata, rd_t[c]); end
      next_cycle();
    end
    reset = 1'b0;
    bus1.data_stall = 1'b0;
  endtask

  task automatic test_wrap();
    logic        req_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        wr_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] adr_t [4] = '{32'h00004000, 32'h0, 32'h0, 32'h0};
    logic        dok_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd_t  [4] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    for (int c = 0; c < 4; c++) begin
      drive1(req_t[c], wr_t[c], adr_t[c], 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      vec_cnt++; if (bus1.data_ok !== dok_t[c]) begin err_cnt++; $display("FAIL wrap_data_ok c%0d: got %b want %b", c, bus1.data_ok, dok_t[c]); end
      vec_cnt++; if (bus1.rdata !== rd_t[c]) begin err_cnt++; $display("FAIL wrap_rdata c%0d: got %h want %h", c, bus1.rdata, rd_t[c]); end
      next_cycle();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_partial_write();
    test_latency3();
    test_back_to_back();
    test_data_stall();
    test_addr_stall();
    test_reset_midop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
